instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the main/ALU control decoder and datapath of the MIPS-style core.
//  Holds the PC and requests instructions from instruction memory with a req/ack handshake.
//  Registers each returned word and splits it into opcode/funct/register/immediate fields.
//  Selects the next PC from the Branch, Zero and Jump signals, with wait-state and timeout support.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded at reset (word aligned)
//  MAX_WAIT  15             cycles FETCH may wait for imem_ack before error (1..255)
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  rst_n        in   1   synchronous reset, active-low
//  imem_req     out  1   fetch request, high only in FETCH
//  imem_addr    out  32  byte address of fetch (= pc)
//  imem_ack     in   1   memory has valid data this cycle
//  imem_rdata   in   32  instruction word, sampled only when imem_req & imem_ack
//  stall        in   1   hold the current instruction in ISSUE
//  branch       in   1   Branch from control decoder
//  zero         in   1   ALU zero flag
//  jump         in   1   Jump from control decoder
//  instr        out  32  registered instruction
//  opcode       out  6   instr[31:26], to control decoder OpCode
//  funct        out  6   instr[5:0], to control decoder Funct
//  rs/rt/rd     out  5   instr[25:21]/[20:16]/[15:11]
//  imm          out  16  instr[15:0]
//  instr_valid  out  1   high exactly while in ISSUE
//  pc           out  32  address of the current instruction
//  pc_plus4     out  32  pc + 4, modulo 2^32
//  fetch_err    out  1   sticky memory timeout flag
// BEHAVIOUR
//  Reset (rst_n=0 at an edge) sets: state=IDLE, pc=RESET_PC, instr=0, wait_cnt=0, fetch_err=0.
//  While in IDLE after reset, imem_req=0, instr_valid=0, and all field outputs are 0.
//  Reset has priority in any state. A fetch in flight is abandoned, and a late ack is ignored.
//  IDLE->FETCH: unconditionally on the next edge.
//  FETCH: imem_req=1, imem_addr=pc.
//    On ack: instr<=imem_rdata, wait_cnt<=0, go to ISSUE.
//    No ack: wait_cnt++. If no ack while wait_cnt==MAX_WAIT, go to ERROR.
//    Latency: ack at edge N makes instr_valid=1 during cycle N+1.
//  ISSUE: instr_valid=1, and the decoder/datapath execute combinationally.
//    stall=1: remain in ISSUE. pc, instr and outputs are held.
//    stall=0: pc<=next_pc, go to FETCH, instr_valid=0 in the next cycle.
//  next_pc priority:
//    jump: {pc_plus4[31:28], instr[25:0], 2'b00}
//    else branch&zero: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00})
//    else: pc_plus4
//  All adds are 32-bit and wrap mod 2^32. There is no alignment check.
//  branch, zero and jump are ignored outside ISSUE. imem_ack is ignored when imem_req=0.
//  ERROR: sticky until reset. fetch_err=1, imem_req=0, instr_valid=0, pc and instr frozen.
//  Field outputs are always slices of the instr register, so they are constant outside ISSUE updates.
// TESTING
//  Reset: hold rst_n=0 for 2 cycles -> pc=0, imem_req=0, instr_valid=0.
//    Release -> imem_req=1 one cycle later, with imem_addr=0.
//  Zero-wait fetch: ack with 0x00221820 -> next cycle instr_valid=1, opcode=0, funct=0x20,
//    rs=1, rt=2, rd=3. With stall=0 and no branch/jump -> pc=4.
//  Branch: pc=0x10, instr 0x1022FFFD, branch=1, zero=1 -> pc=0x08.
//    Same instruction with zero=0 -> pc=0x14.
//  Jump priority: pc=0x4000_0010, instr 0x08000100, jump=1, branch=1, zero=1 -> pc=0x4000_0400.
//  Stall and wait states: ack delayed 3 cycles -> instr_valid rises 4 cycles after req.
//    stall=1 for 3 cycles -> instr_valid, pc and instr held for the full stall.
//  Timeout and wrap: no ack for MAX_WAIT+1 cycles -> fetch_err=1, imem_req=0, sticky. Reset clears it.
//    RESET_PC=0xFFFF_FFFC -> second fetch address is 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words over a req/ack handshake,
// decodes the instruction fields and selects the next PC from branch/zero/jump.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        jump_i,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [5:0]  funct_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [15:0] imm_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  // Jump outranks a taken branch; both are only consulted while in ISSUE.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_i) begin
      next_pc = jump_tgt;
    end else if (branch_i && zero_i) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        wait_cnt_d = 8'd0;
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          instr_d    = imem_rdata_i;
          wait_cnt_d = 8'd0;
          state_d    = S_ISSUE;
        end else if (wait_cnt_q == MaxWait) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        if (!stall_i) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == S_ISSUE);
  assign fetch_err_o   = (state_q == S_ERROR);
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;

  assign instr_o  = instr_q;
  assign opcode_o = instr_q[31:26];
  assign funct_o  = instr_q[5:0];
  assign rs_o     = instr_q[25:21];
  assign rt_o     = instr_q[20:16];
  assign rd_o     = instr_q[15:11];
  assign imm_o    = instr_q[15:0];

endmodule
